// File: rtl/int_ack_responder.sv
// Processor-side interrupt acknowledge responder: accepts a level request at an
// instruction boundary, issues a delayed one-cycle ack plus vector load, and tracks the ISR.
module int_ack_responder #(
  parameter int ACK_DELAY = 2,
  parameter int COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               interrupt,
  input  logic               int_en_set,
  input  logic               int_en_clr,
  input  logic               busy,
  input  logic               returni,
  input  logic               returni_en,
  output logic               interrupt_ack,
  output logic               vector_load,
  output logic               in_isr,
  output logic               ie,
  output logic [COUNT_W-1:0] isr_count,
  output logic               spurious
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    SERVICE
  } state_t;

  localparam logic [3:0] DELAY = 4'(ACK_DELAY);

  state_t             state, state_d;
  logic [3:0]         cnt, cnt_d;
  logic               ie_d, ie_upd, ack_d, in_isr_d, spurious_d;
  logic [COUNT_W-1:0] count_d;

  // Disable wins when both enable pulses arrive together.
  always_comb begin
    ie_upd = ie;
    if (int_en_clr)
      ie_upd = 1'b0;
    else if (int_en_set)
      ie_upd = 1'b1;
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ie_d       = ie;
    ack_d      = 1'b0;
    in_isr_d   = in_isr;
    spurious_d = spurious;
    count_d    = isr_count;
    case (state)
      IDLE: begin
        ie_d = ie_upd;
        if (interrupt && ie && !busy) begin
          cnt_d   = DELAY;
          state_d = (DELAY == 4'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        ie_d = ie_upd;
        // A withdrawn request means there is nothing left to vector to.
        if (!interrupt) begin
          state_d    = IDLE;
          spurious_d = 1'b1;
          cnt_d      = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_d = ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ACK: begin
        ack_d    = 1'b1;
        in_isr_d = 1'b1;
        ie_d     = 1'b0;
        count_d  = isr_count + COUNT_W'(1);
        state_d  = SERVICE;
      end
      SERVICE: begin
        if (returni) begin
          state_d  = IDLE;
          in_isr_d = 1'b0;
          ie_d     = returni_en;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      ie            <= 1'b0;
      in_isr        <= 1'b0;
      interrupt_ack <= 1'b0;
      vector_load   <= 1'b0;
      isr_count     <= '0;
      spurious      <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      ie            <= ie_d;
      in_isr        <= in_isr_d;
      interrupt_ack <= ack_d;
      vector_load   <= ack_d;
      isr_count     <= count_d;
      spurious      <= spurious_d;
    end
  end

endmodule
